// File: rtl/dbg_slave_arb.sv
// Arbitrates the core instruction port and a bus device onto the single
// debug-module memory slave, with starvation protection for instruction fetches.
module dbg_slave_arb #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned MaxWait   = 4
) (
   input  logic                   clk_sys_i,
   input  logic                   rst_sys_ni,

   input  logic                   instr_req_i,
   input  logic [AddrWidth-1:0]   instr_addr_i,
   output logic                   instr_gnt_o,
   output logic                   instr_rvalid_o,
   output logic [DataWidth-1:0]   instr_rdata_o,

   input  logic                   data_req_i,
   input  logic                   data_we_i,
   input  logic [DataWidth/8-1:0] data_be_i,
   input  logic [AddrWidth-1:0]   data_addr_i,
   input  logic [DataWidth-1:0]   data_wdata_i,
   output logic                   data_gnt_o,
   output logic                   data_rvalid_o,
   output logic [DataWidth-1:0]   data_rdata_o,

   output logic                   slave_req_o,
   output logic                   slave_we_o,
   output logic [DataWidth/8-1:0] slave_be_o,
   output logic [AddrWidth-1:0]   slave_addr_o,
   output logic [DataWidth-1:0]   slave_wdata_o,
   input  logic [DataWidth-1:0]   slave_rdata_i
);

   localparam int unsigned BeWidth   = DataWidth / 8;
   localparam logic [3:0]  StarveMax = 4'(MaxWait);

   logic [3:0] r_starve;
   logic       r_rspValid;
   logic       r_rspSel;

   logic       w_forceInstr;
   logic       w_instrGnt;
   logic       w_dataGnt;
   logic       w_slaveReq;
   logic       w_instrRvalid;
   logic       w_dataRvalid;

   assign w_forceInstr = (r_starve == StarveMax);

   // Data normally wins a collision; once the fetch side has lost MaxWait
   // times in a row it takes the slot. Reset forces every grant low.
   always_comb begin
      w_instrGnt = 1'b0;
      w_dataGnt  = 1'b0;
      if (rst_sys_ni) begin
         w_instrGnt = instr_req_i & (~data_req_i | w_forceInstr);
         w_dataGnt  = data_req_i & ~w_instrGnt;
      end
   end

   assign w_slaveReq  = w_instrGnt | w_dataGnt;
   assign instr_gnt_o = w_instrGnt;
   assign data_gnt_o  = w_dataGnt;
   assign slave_req_o = w_slaveReq;

   // Counts consecutive lost fetch cycles; any fetch grant or idle fetch clears it.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         r_starve <= 4'd0;
      end else if (instr_req_i && !w_instrGnt) begin
         if (r_starve != StarveMax) begin
            r_starve <= r_starve + 4'd1;
         end
      end else begin
         r_starve <= 4'd0;
      end
   end

   // Fetches are always full-word reads; an idle slave sees an all-zero command.
   always_comb begin
      slave_we_o    = 1'b0;
      slave_be_o    = '0;
      slave_addr_o  = '0;
      slave_wdata_o = '0;
      if (w_instrGnt) begin
         slave_be_o   = {BeWidth{1'b1}};
         slave_addr_o = instr_addr_i;
      end else if (w_dataGnt) begin
         slave_we_o    = data_we_i;
         slave_be_o    = data_be_i;
         slave_addr_o  = data_addr_i;
         slave_wdata_o = data_wdata_i;
      end
   end

   // The slave answers one cycle after every accepted command, so a single
   // stage remembering who was granted is enough for full throughput.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         r_rspValid <= 1'b0;
         r_rspSel   <= 1'b0;
      end else begin
         r_rspValid <= w_slaveReq;
         r_rspSel   <= w_dataGnt;
      end
   end

   assign w_instrRvalid  = r_rspValid & ~r_rspSel;
   assign w_dataRvalid   = r_rspValid & r_rspSel;
   assign instr_rvalid_o = w_instrRvalid;
   assign data_rvalid_o  = w_dataRvalid;
   assign instr_rdata_o  = {DataWidth{w_instrRvalid}} & slave_rdata_i;
   assign data_rdata_o   = {DataWidth{w_dataRvalid}} & slave_rdata_i;

endmodule

// File: tb/tb_dbg_slave_arb.sv
// Self-checking bench for dbg_slave_arb: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_dbg_slave_arb;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4;

   logic          clk_sys_i = 1'b0;
   logic          rst_sys_ni;
   logic          instr_req_i;
   logic [AW-1:0] instr_addr_i;
   logic          instr_gnt_o;
   logic          instr_rvalid_o;
   logic [DW-1:0] instr_rdata_o;
   logic          data_req_i;
   logic          data_we_i;
   logic [3:0]    data_be_i;
   logic [AW-1:0] data_addr_i;
   logic [DW-1:0] data_wdata_i;
   logic          data_gnt_o;
   logic          data_rvalid_o;
   logic [DW-1:0] data_rdata_o;
   logic          slave_req_o;
   logic          slave_we_o;
   logic [3:0]    slave_be_o;
   logic [AW-1:0] slave_addr_o;
   logic [DW-1:0] slave_wdata_o;
   logic [DW-1:0] slave_rdata_i;

   dbg_slave_arb #(.AddrWidth(AW), .DataWidth(DW), .MaxWait(MW)) dut (
      .clk_sys_i     (clk_sys_i),
      .rst_sys_ni    (rst_sys_ni),
      .instr_req_i   (instr_req_i),
      .instr_addr_i  (instr_addr_i),
      .instr_gnt_o   (instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o (instr_rdata_o),
      .data_req_i    (data_req_i),
      .data_we_i     (data_we_i),
      .data_be_i     (data_be_i),
      .data_addr_i   (data_addr_i),
      .data_wdata_i  (data_wdata_i),
      .data_gnt_o    (data_gnt_o),
      .data_rvalid_o (data_rvalid_o),
      .data_rdata_o  (data_rdata_o),
      .slave_req_o   (slave_req_o),
      .slave_we_o    (slave_we_o),
      .slave_be_o    (slave_be_o),
      .slave_addr_o  (slave_addr_o),
      .slave_wdata_o (slave_wdata_o),
      .slave_rdata_i (slave_rdata_i)
   );

   always #5 clk_sys_i = ~clk_sys_i;

   int total = 0;
   int bad   = 0;

   // Reference model: how many cycles the fetch side has been losing, and
   // which side (if any) is owed a response next cycle.
   int mLosses     = 0;
   bit mPendValid  = 1'b0;
   bit mPendIsData = 1'b0;

   int dutWaitRun = 0;

   logic          obsIGnt;
   logic          obsDGnt;
   logic [DW-1:0] obsIRdata;
   logic          obsIRvalid;
   logic          obsDRvalid;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drives one cycle of inputs (called #1 after a rising edge), checks the
   // DUT on the falling edge and advances the model by one clock.
   task automatic applyStimulus(input bit rstN, input bit iReq, input logic [31:0] iAddr,
                                input bit dReq, input bit dWe, input logic [3:0] dBe,
                                input logic [31:0] dAddr, input logic [31:0] dWdata,
                                input logic [31:0] slvRdata);
      bit            expI;
      bit            expD;
      bit            expIRv;
      bit            expDRv;
      logic          expWe;
      logic [3:0]    expBe;
      logic [31:0]   expAddr;
      logic [31:0]   expWdata;

      rst_sys_ni    = rstN;
      instr_req_i   = iReq;
      instr_addr_i  = iAddr;
      data_req_i    = dReq;
      data_we_i     = dWe;
      data_be_i     = dBe;
      data_addr_i   = dAddr;
      data_wdata_i  = dWdata;
      slave_rdata_i = slvRdata;

      expI = 1'b0;
      expD = 1'b0;
      if (rstN) begin
         if (iReq && dReq) begin
            if (mLosses >= MW) expI = 1'b1;
            else               expD = 1'b1;
         end else begin
            expI = iReq;
            expD = dReq;
         end
      end

      expWe = 1'b0; expBe = 4'h0; expAddr = 32'h0; expWdata = 32'h0;
      if (expI) begin
         expBe = 4'hF; expAddr = iAddr;
      end else if (expD) begin
         expWe = dWe; expBe = dBe; expAddr = dAddr; expWdata = dWdata;
      end

      expIRv = rstN && mPendValid && !mPendIsData;
      expDRv = rstN && mPendValid && mPendIsData;

      @(negedge clk_sys_i);
      checkOutput("instrGnt",   64'(instr_gnt_o),    64'(expI));
      checkOutput("dataGnt",    64'(data_gnt_o),     64'(expD));
      checkOutput("oneGnt",     64'(instr_gnt_o & data_gnt_o), 64'd0);
      checkOutput("slaveReq",   64'(slave_req_o),    64'(expI | expD));
      checkOutput("slaveWe",    64'(slave_we_o),     64'(expWe));
      checkOutput("slaveBe",    64'(slave_be_o),     64'(expBe));
      checkOutput("slaveAddr",  64'(slave_addr_o),   64'(expAddr));
      checkOutput("slaveWdata", 64'(slave_wdata_o),  64'(expWdata));
      checkOutput("instrRvalid",64'(instr_rvalid_o), 64'(expIRv));
      checkOutput("dataRvalid", 64'(data_rvalid_o),  64'(expDRv));
      checkOutput("instrRdata", 64'(instr_rdata_o),  64'(expIRv ? slvRdata : 32'h0));
      checkOutput("dataRdata",  64'(data_rdata_o),   64'(expDRv ? slvRdata : 32'h0));

      if (rstN && iReq && !instr_gnt_o) dutWaitRun++;
      else                              dutWaitRun = 0;
      checkOutput("waitBound", 64'(dutWaitRun <= MW), 64'd1);

      obsIGnt    = instr_gnt_o;
      obsDGnt    = data_gnt_o;
      obsIRdata  = instr_rdata_o;
      obsIRvalid = instr_rvalid_o;
      obsDRvalid = data_rvalid_o;

      if (!rstN) begin
         mLosses     = 0;
         mPendValid  = 1'b0;
         mPendIsData = 1'b0;
      end else begin
         mPendValid  = expI | expD;
         mPendIsData = expD;
         if (iReq && !expI) mLosses = (mLosses < MW) ? mLosses + 1 : MW;
         else               mLosses = 0;
      end

      @(posedge clk_sys_i);
      #1;
   endtask

   task automatic idleCycle(input logic [31:0] slvRdata);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, slvRdata);
   endtask

   initial begin
      rst_sys_ni = 1'b0; instr_req_i = 1'b0; instr_addr_i = '0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0;
      data_addr_i = '0; data_wdata_i = '0; slave_rdata_i = '0;
      @(posedge clk_sys_i);
      #1;

      // Grants must stay low while reset is held, whatever is requested.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'($urandom), 4'($urandom),
                       $urandom, $urandom, $urandom);
      idleCycle(32'h0);

      // Lone fetch followed by its response.
      applyStimulus(1'b1, 1'b1, 32'h1A110800, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      checkOutput("fetchGnt", 64'(obsIGnt), 64'd1);
      idleCycle(32'h00100073);
      checkOutput("fetchRvalid", 64'(obsIRvalid), 64'd1);
      checkOutput("fetchRdata", 64'(obsIRdata), 64'h00100073);
      checkOutput("fetchNoDataRv", 64'(obsDRvalid), 64'd0);

      // Lone data write gets a response one cycle later.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h1A110100, 32'hDEADBEEF, 32'h0);
      idleCycle(32'h12345678);
      checkOutput("writeRvalid", 64'(obsDRvalid), 64'd1);
      checkOutput("writeNoInstrRv", 64'(obsIRvalid), 64'd0);

      // Continuous contention: four data wins then one forced fetch.
      idleCycle(32'h0);
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h1000 + 32'(i), 1'b1, 1'($urandom), 4'($urandom),
                       32'h2000 + 32'(i), $urandom, $urandom);
         checkOutput("prioPattern", 64'(obsIGnt), 64'((i % 5) == 4));
      end
      idleCycle($urandom);

      // Alternating lone requesters, back to back.
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0)
            applyStimulus(1'b1, 1'b1, 32'h3000 + 32'(i), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, $urandom);
         else
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h4000 + 32'(i), 32'h0, $urandom);
         if (i > 0) checkOutput("altRvalid", 64'(obsIRvalid | obsDRvalid), 64'd1);
      end
      idleCycle($urandom);
      checkOutput("altLastRvalid", 64'(obsDRvalid), 64'd1);

      // Reset pulsed right after a data grant discards the pending response.
      applyStimulus(1'b1, 1'b1, 32'h5000, 1'b1, 1'b0, 4'hF, 32'h6000, 32'h0, $urandom);
      checkOutput("preRstDataGnt", 64'(obsDGnt), 64'd1);
      applyStimulus(1'b0, 1'b1, 32'h5000, 1'b1, 1'b0, 4'hF, 32'h6000, 32'h0, $urandom);
      checkOutput("rstDropRvalid", 64'(obsDRvalid), 64'd0);
      applyStimulus(1'b1, 1'b1, 32'h5004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, $urandom);
      checkOutput("postRstGnt", 64'(obsIGnt), 64'd1);
      checkOutput("postRstNoRv", 64'(obsDRvalid), 64'd0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(1'($urandom_range(0, 299) != 0),
                       1'($urandom_range(0, 3) != 0), $urandom,
                       1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                       $urandom, $urandom, $urandom);
      end
      idleCycle($urandom);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dbg_slave_arb.md
DBG_SLAVE_ARB -- requirements
Module: dbg_slave_arb

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter DataWidth, default 32, meaning data width of all ports.
REQ-003 SHALL have parameter MaxWait, default 4, range 1..15, meaning consecutive instruction-side losses before instruction priority is forced.
REQ-004 clk_sys_i  input  1  system clock; all state on rising edge.
REQ-005 rst_sys_ni  input  1  reset, asynchronous, active-low.
REQ-006 instr_req_i  input  1  fetch request from core instruction port.
REQ-007 instr_addr_i  input  AddrWidth  fetch address.
REQ-008 instr_gnt_o  output  1  fetch request accepted this cycle.
REQ-009 instr_rvalid_o  output  1  fetch read data valid.
REQ-010 instr_rdata_o  output  DataWidth  fetch read data.
REQ-011 data_req_i  input  1  bus-device request.
REQ-012 data_we_i  input  1  bus-device write enable.
REQ-013 data_be_i  input  DataWidth/8  bus-device byte enables.
REQ-014 data_addr_i  input  AddrWidth  bus-device address.
REQ-015 data_wdata_i  input  DataWidth  bus-device write data.
REQ-016 data_gnt_o  output  1  bus-device request accepted this cycle.
REQ-017 data_rvalid_o  output  1  bus-device response valid (reads and writes).
REQ-018 data_rdata_o  output  DataWidth  bus-device read data.
REQ-019 slave_req_o  output  1  request to debug-module memory slave.
REQ-020 slave_we_o / slave_be_o / slave_addr_o / slave_wdata_o  output  1 / DataWidth/8 / AddrWidth / DataWidth  slave command fields.
REQ-021 slave_rdata_i  input  DataWidth  slave read data, valid exactly one cycle after slave_req_o.

Function
REQ-022 Slave SHALL be treated as always-ready; every cycle with slave_req_o=1 is one accepted transaction.
REQ-023 At most one of instr_gnt_o, data_gnt_o SHALL be high per cycle; slave_req_o SHALL equal instr_gnt_o|data_gnt_o; grants combinational from current requests.
REQ-024 Default priority: data wins when both request; instr wins when force_instr is set (REQ-027).
REQ-025 Lone requester SHALL be granted the same cycle.
REQ-026 starve counter (width 4) SHALL increment, saturating at MaxWait, each cycle instr_req_i=1 and instr_gnt_o=0; SHALL clear on any instr grant or when instr_req_i=0.
REQ-027 force_instr SHALL be combinationally (starve==MaxWait); with force_instr and both requesting, instr granted, data held off one cycle, counter cleared.
REQ-028 Slave command fields SHALL mux from granted requester; instr grant drives we=0, be=all-ones, wdata=0; no grant drives all fields 0.
REQ-029 Response tracker SHALL register rsp_valid_q<=slave_req_o and rsp_sel_q<=data_gnt_o (1=data) each cycle.
REQ-030 instr_rvalid_o = rsp_valid_q & ~rsp_sel_q; data_rvalid_o = rsp_valid_q & rsp_sel_q; exactly one cycle after grant, no other latency.
REQ-031 Data writes SHALL produce data_rvalid_o one cycle after grant (rdata content don't-care but gated per REQ-032).
REQ-032 instr_rdata_o / data_rdata_o SHALL equal slave_rdata_i while own rvalid high, else all-zero.
REQ-033 Back-to-back grants (any mix) every cycle SHALL be supported at full throughput; response n+1 SHALL immediately follow response n.
REQ-034 Requests deasserted without grant SHALL be dropped with no state effect other than REQ-026.

Reset
REQ-035 On rst_sys_ni low: rsp_valid_q=0, rsp_sel_q=0, starve=0 asynchronously; all rvalid outputs 0, rdata outputs 0.
REQ-036 During reset grants and slave_req_o SHALL be 0 regardless of inputs.
REQ-037 Reset asserted with a response pending SHALL discard it; no rvalid after release.

Verification
REQ-038 Lone instr read addr 0x1A110800, slave_rdata_i=0x00100073 next cycle -> instr_gnt_o=1 cycle 0, instr_rvalid_o=1 cycle 1 with rdata 0x00100073, data_rvalid_o=0.
REQ-039 Data write addr 0x1A110100 be=0xF wdata=0xDEADBEEF -> slave_we_o=1 same cycle, data_rvalid_o=1 next cycle, instr_rvalid_o=0.
REQ-040 Both requesting continuously, MaxWait=4 -> grant pattern D,D,D,D,I repeating; instr waits at most 4 cycles.
REQ-041 Alternating lone instr/data each cycle for 8 cycles -> 8 consecutive rvalids, each on the correct side, rdata routed.
REQ-042 Reset pulsed the cycle after a data grant -> no data_rvalid_o after release; starve=0; first post-reset request granted same cycle.
REQ-043 Random traffic 10k cycles vs reference model -> never two grants, every grant yields exactly one rvalid one cycle later on the granted side.
